// File: rtl/irq_priority_arbiter.sv
// Sequential priority interrupt arbiter: captures per-bus channel requests into pending state
// and presents one eligible (bus, channel) winner at a time over a valid/ack handshake.
module irq_priority_arbiter #(
   parameter int unsigned NUM_CH      = 9,
   parameter int unsigned NUM_BUS     = 3,
   parameter int unsigned EDGE_MODE   = 0,
   parameter int unsigned ROUND_ROBIN = 0,
   parameter bit          MASK_RST    = 1'b0,
   localparam int unsigned BusW = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1,
   localparam int unsigned ChW  = $clog2(NUM_CH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_BUS*NUM_CH-1:0]  req_i,
   input  logic [NUM_CH-1:0]          en_i,
   input  logic                       mask_wr_i,
   input  logic [NUM_CH-1:0]          mask_data_i,
   output logic                       irq_valid_o,
   output logic [BusW-1:0]            irq_bus_o,
   output logic [ChW-1:0]             irq_ch_o,
   input  logic                       irq_ack_i,
   output logic [NUM_BUS-1:0]         bus_active_o,
   output logic [NUM_BUS*NUM_CH-1:0]  pend_o
);

   typedef enum logic [0:0] {StIdle, StPresent} state_e;

   state_e                          state_q, state_d;
   logic [NUM_BUS*NUM_CH-1:0]       pend_q, pend_d;
   logic [NUM_BUS*NUM_CH-1:0]       req_q;
   logic [NUM_CH-1:0]               mask_q, mask_d;
   logic [NUM_BUS-1:0][ChW-1:0]     ptr_q, ptr_d;
   logic [NUM_BUS-1:0]              bus_active_q, bus_active_d;
   logic [BusW-1:0]                 bus_q, bus_d;
   logic [ChW-1:0]                  ch_q, ch_d;

   logic [NUM_BUS*NUM_CH-1:0]       set, clr, elig;
   logic                            any_elig;
   logic [BusW-1:0]                 win_bus;
   logic [ChW-1:0]                  win_ch;
   logic [ChW:0]                    ch_inc;
   logic [ChW-1:0]                  ch_next;

   assign set      = (EDGE_MODE != 0) ? (req_i & ~req_q) : req_i;
   assign elig     = pend_q & {NUM_BUS{en_i & ~mask_q}};
   assign any_elig = |elig;

   // Pointer after the served channel, wrapping at NUM_CH.
   assign ch_inc  = {1'b0, ch_q} + {{ChW{1'b0}}, 1'b1};
   assign ch_next = (ch_inc == (ChW+1)'(NUM_CH)) ? '0 : ch_inc[ChW-1:0];

   always_comb begin
      logic found;
      logic ch_found;
      int   k;
      found    = 1'b0;
      ch_found = 1'b0;
      k        = 0;
      win_bus  = '0;
      win_ch   = '0;
      for (int b = 0; b < int'(NUM_BUS); b++) begin
         if (!found && (|elig[b*NUM_CH +: NUM_CH])) begin
            found    = 1'b1;
            ch_found = 1'b0;
            win_bus  = BusW'(b);
            for (int i = 0; i < int'(NUM_CH); i++) begin
               k = (ROUND_ROBIN != 0) ? int'(ptr_q[b]) + i : i;
               if (k >= int'(NUM_CH)) k = k - int'(NUM_CH);
               if (!ch_found && elig[b*NUM_CH + k]) begin
                  ch_found = 1'b1;
                  win_ch   = ChW'(k);
               end
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bus_d   = bus_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      clr     = '0;
      unique case (state_q)
         StIdle: begin
            if (any_elig) begin
               bus_d   = win_bus;
               ch_d    = win_ch;
               state_d = StPresent;
            end
         end
         StPresent: begin
            // Outputs stay frozen until ack; no retraction or preemption.
            if (irq_ack_i) begin
               clr[int'(bus_q)*NUM_CH + int'(ch_q)] = 1'b1;
               ptr_d[bus_q] = ch_next;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      pend_d = (pend_q & ~clr) | set;
      mask_d = mask_wr_i ? mask_data_i : mask_q;
      for (int b = 0; b < int'(NUM_BUS); b++) begin
         bus_active_d[b] = |elig[b*NUM_CH +: NUM_CH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pend_q       <= '0;
         req_q        <= '0;
         mask_q       <= {NUM_CH{MASK_RST}};
         ptr_q        <= '0;
         bus_active_q <= '0;
         bus_q        <= '0;
         ch_q         <= '0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         req_q        <= req_i;
         mask_q       <= mask_d;
         ptr_q        <= ptr_d;
         bus_active_q <= bus_active_d;
         bus_q        <= bus_d;
         ch_q         <= ch_d;
      end
   end

   assign irq_valid_o  = (state_q == StPresent);
   assign irq_bus_o    = bus_q;
   assign irq_ch_o     = ch_q;
   assign bus_active_o = bus_active_q;
   assign pend_o       = pend_q;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed bench: three arbiter instances (fixed/level, round-robin, edge) share one stimulus set.
module tb_irq_priority_arbiter;

   localparam int NCH = 9;
   localparam int NB  = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NB*NCH-1:0] req = '0;
   logic [NCH-1:0]   en = 9'h1FF;
   logic             mask_wr = 1'b0;
   logic [NCH-1:0]   mask_data = '0;
   logic             ack = 1'b0;

   logic             v0, v1, v2;
   logic [1:0]       b0, b1, b2;
   logic [3:0]       c0, c1, c2;
   logic [NB-1:0]    ba0, ba1, ba2;
   logic [NB*NCH-1:0] p0, p1, p2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   irq_priority_arbiter u_fix (
      .clk(clk), .rst_n(rst_n), .req_i(req), .en_i(en), .mask_wr_i(mask_wr),
      .mask_data_i(mask_data), .irq_valid_o(v0), .irq_bus_o(b0), .irq_ch_o(c0),
      .irq_ack_i(ack), .bus_active_o(ba0), .pend_o(p0)
   );

   irq_priority_arbiter #(.ROUND_ROBIN(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req_i(req), .en_i(en), .mask_wr_i(mask_wr),
      .mask_data_i(mask_data), .irq_valid_o(v1), .irq_bus_o(b1), .irq_ch_o(c1),
      .irq_ack_i(ack), .bus_active_o(ba1), .pend_o(p1)
   );

   irq_priority_arbiter #(.EDGE_MODE(1)) u_edge (
      .clk(clk), .rst_n(rst_n), .req_i(req), .en_i(en), .mask_wr_i(mask_wr),
      .mask_data_i(mask_data), .irq_valid_o(v2), .irq_bus_o(b2), .irq_ch_o(c2),
      .irq_ack_i(ack), .bus_active_o(ba2), .pend_o(p2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req     = '0;
      ack     = 1'b0;
      mask_wr = 1'b0;
      rst_n   = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   int exp_rr [4] = '{1, 3, 7, 1};
   int cnt;
   bit got_v;

   initial begin
      // Priority across and within buses
      do_reset();
      check("rst_valid", 64'(v0), 64'd0);
      check("rst_pend", 64'(p0), 64'd0);
      check("rst_active", 64'(ba0), 64'd0);
      check("rst_bus", 64'(b0), 64'd0);
      check("rst_ch", 64'(c0), 64'd0);
      req[1*NCH+2] = 1'b1;
      req[0*NCH+5] = 1'b1;
      step();
      req = '0;
      check("t1_pend", 64'(p0), 64'h820);
      check("t1_no_valid_yet", 64'(v0), 64'd0);
      step();
      check("t1_valid", 64'(v0), 64'd1);
      check("t1_bus0", 64'(b0), 64'd0);
      check("t1_ch5", 64'(c0), 64'd5);
      check("t1_active", 64'(ba0), 64'b011);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("t1_bubble", 64'(v0), 64'd0);
      check("t1_hold_ch", 64'(c0), 64'd5);
      check("t1_pend_after_ack", 64'(p0), 64'h800);
      step();
      check("t1_valid2", 64'(v0), 64'd1);
      check("t1_bus1", 64'(b0), 64'd1);
      check("t1_ch2", 64'(c0), 64'd2);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("t1_pend_empty", 64'(p0), 64'd0);
      check("t1_idle", 64'(v0), 64'd0);

      // Hold under higher-priority arrival
      do_reset();
      req[2*NCH+0] = 1'b1;
      step();
      req = '0;
      step();
      check("t2_bus2", 64'(b0), 64'd2);
      req[0] = 1'b1;
      step();
      step();
      check("t2_hold_valid", 64'(v0), 64'd1);
      check("t2_hold_bus", 64'(b0), 64'd2);
      check("t2_hold_ch", 64'(c0), 64'd0);
      ack = 1'b1;
      step();
      ack = 1'b0;
      step();
      check("t2_next_valid", 64'(v0), 64'd1);
      check("t2_next_bus", 64'(b0), 64'd0);
      req = '0;
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("t2_pend_clear", 64'(p0), 64'd0);

      // Mask and re-enable
      do_reset();
      mask_wr = 1'b1;
      mask_data = 9'h010;
      step();
      mask_wr = 1'b0;
      req[4] = 1'b1;
      step();
      req = '0;
      step();
      step();
      check("t3_pend_masked", 64'(p0), 64'h10);
      check("t3_active_masked", 64'(ba0), 64'd0);
      check("t3_no_valid", 64'(v0), 64'd0);
      mask_wr = 1'b1;
      mask_data = '0;
      step();
      mask_wr = 1'b0;
      check("t3_not_yet", 64'(v0), 64'd0);
      step();
      check("t3_valid", 64'(v0), 64'd1);
      check("t3_ch4", 64'(c0), 64'd4);

      // Round robin, level requests held high
      do_reset();
      req[1] = 1'b1;
      req[3] = 1'b1;
      req[7] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         got_v = 1'b0;
         for (int w = 0; w < 8 && !got_v; w++) begin
            step();
            got_v = v1;
         end
         check("t4_valid_seen", 64'(got_v), 64'd1);
         check("t4_rr_ch", 64'(c1), 64'(exp_rr[n]));
         ack = 1'b1;
         step();
         ack = 1'b0;
      end

      // Edge mode: one presentation per rising edge
      do_reset();
      req[6] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ack) ack = 1'b0;
         else if (v2) begin
            cnt++;
            ack = 1'b1;
         end
      end
      check("t5_one_present", 64'(cnt), 64'd1);
      check("t5_pend_clear", 64'(p2), 64'd0);
      req = '0;
      step();
      req[6] = 1'b1;
      step();
      step();
      check("t5_valid", 64'(v2), 64'd1);
      check("t5_ch6", 64'(c2), 64'd6);
      req = '0;
      step();
      req[6] = 1'b1;
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("t5_repend_on_ack", 64'(p2), 64'h40);
      check("t5_valid_dropped", 64'(v2), 64'd0);

      // Asynchronous reset mid-presentation
      do_reset();
      mask_wr = 1'b1;
      mask_data = 9'h001;
      step();
      mask_wr = 1'b0;
      req[2] = 1'b1;
      step();
      req = '0;
      step();
      check("t6_valid_pre", 64'(v0), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", 64'(v0), 64'd0);
      check("t6_async_pend", 64'(p0), 64'd0);
      #2 rst_n = 1'b1;
      req[0] = 1'b1;
      ack = 1'b1;
      step();
      req = '0;
      ack = 1'b0;
      check("t6_stray_ack", 64'(p0), 64'd1);
      check("t6_stray_valid", 64'(v0), 64'd0);
      step();
      check("t6_mask_restored", 64'(v0), 64'd1);
      check("t6_ch0", 64'(c0), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
